// File: rtl/regfile_pkg.sv
// Shared types for the register file: command opcodes and FSM states.
// Optional feature macro: REGFILE_SWAP_EN (enables the SWAP command).
package regfile_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 2'b00,
    OP_MOV  = 2'b01,
    OP_LOAD = 2'b10,
    OP_SWAP = 2'b11
  } cmd_op_e;

`ifdef REGFILE_SWAP_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_WRITE2 = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/regfile_fsm.sv
// Command sequencer for the register file: captures commands, steps through
// read/write phases and stalls writes that collide with an accumulator write.
// Optional feature macro: REGFILE_SWAP_EN (adds the WRITE2 phase for SWAP).
module regfile_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned AW      = 3,
  parameter int unsigned ACC_IDX = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_cmd_valid,
  input  logic [OP_W-1:0] i_cmd_op,
  input  logic [AW-1:0]   i_cmd_src,
  input  logic [AW-1:0]   i_cmd_dst,
  input  logic            i_acc_we,
  output logic            o_cmd_ready_c,
  output logic            o_cmd_done_c,
  output logic            o_cap_imm_c,
  output logic            o_cap_rd_c,
  output logic            o_wr_en_c,
`ifdef REGFILE_SWAP_EN
  output logic            o_wr_b_c,
  output logic [AW-1:0]   o_dst,
`endif
  output logic [AW-1:0]   o_wr_idx_c,
  output logic [AW-1:0]   o_src
);

  localparam logic [AW-1:0] ACC = AW'(ACC_IDX);

  state_e        r_state;
  state_e        w_next;
  cmd_op_e       r_op;
  cmd_op_e       w_op_eff;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic          w_accept;

  assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
  assign o_src    = r_src;
`ifdef REGFILE_SWAP_EN
  assign o_dst    = r_dst;
  assign w_op_eff = cmd_op_e'(i_cmd_op);
`else
  // Without the swap datapath, op 11 degrades to a NOP.
  assign w_op_eff = (cmd_op_e'(i_cmd_op) == OP_SWAP) ? OP_NOP : cmd_op_e'(i_cmd_op);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Command field capture, only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_NOP;
      r_src <= '0;
      r_dst <= '0;
    end else if (w_accept) begin
      r_op  <= w_op_eff;
      r_src <= i_cmd_src;
      r_dst <= i_cmd_dst;
    end
  end

  // Next-state and phase controls; a write to the accumulator waits out acc_we.
  always_comb begin
    w_next        = r_state;
    o_cmd_ready_c = 1'b0;
    o_cmd_done_c  = 1'b0;
    o_cap_imm_c   = 1'b0;
    o_cap_rd_c    = 1'b0;
    o_wr_en_c     = 1'b0;
    o_wr_idx_c    = r_dst;
`ifdef REGFILE_SWAP_EN
    o_wr_b_c      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready_c = 1'b1;
        if (i_cmd_valid) begin
          case (w_op_eff)
            OP_MOV:  w_next = ST_READ;
            OP_SWAP: w_next = ST_READ;
            OP_LOAD: begin
              o_cap_imm_c = 1'b1;
              w_next      = ST_WRITE;
            end
            default: w_next = ST_WRITE;
          endcase
        end
      end
      ST_READ: begin
        o_cap_rd_c = 1'b1;
        w_next     = ST_WRITE;
      end
      ST_WRITE: begin
        if (!((r_op != OP_NOP) && (r_dst == ACC) && i_acc_we)) begin
          o_wr_en_c = (r_op != OP_NOP);
`ifdef REGFILE_SWAP_EN
          if (r_op == OP_SWAP) begin
            w_next = ST_WRITE2;
          end else begin
            o_cmd_done_c = 1'b1;
            w_next       = ST_IDLE;
          end
`else
          o_cmd_done_c = 1'b1;
          w_next       = ST_IDLE;
`endif
        end
      end
`ifdef REGFILE_SWAP_EN
      ST_WRITE2: begin
        o_wr_idx_c = r_src;
        o_wr_b_c   = 1'b1;
        if (!((r_src == ACC) && i_acc_we)) begin
          o_wr_en_c    = 1'b1;
          o_cmd_done_c = 1'b1;
          w_next       = ST_IDLE;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// Small register file with a command sequencer (NOP/MOV/LOAD/SWAP), a direct
// accumulator write port and a combinational debug read port.
// Optional feature macro: REGFILE_SWAP_EN (enables SWAP; otherwise op 11 is a NOP).
module register_file
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_REGS = 8,
  parameter  int unsigned ACC_IDX  = NUM_REGS - 1,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [AW-1:0]     cmd_src,
  input  logic [AW-1:0]     cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              cmd_done,
  input  logic              acc_we,
  input  logic [DATA_W-1:0] acc_in,
  output logic [DATA_W-1:0] acc_out,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [AW-1:0] ACC_A = AW'(ACC_IDX);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_tmp_a;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_src_val;
  logic [AW-1:0]     w_src;
  logic [AW-1:0]     w_wr_idx;
  logic              w_cap_imm;
  logic              w_cap_rd;
  logic              w_wr_en;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_src_ok;
`ifdef REGFILE_SWAP_EN
  logic [DATA_W-1:0] r_tmp_b;
  logic [DATA_W-1:0] w_dst_val;
  logic [AW-1:0]     w_dst;
  logic              w_dst_ok;
  logic              w_wr_b;
`endif

  regfile_fsm #(
    .AW      (AW),
    .ACC_IDX (ACC_IDX)
  ) u_fsm (
    .clk           (clk),
    .rst_n         (reset),
    .i_cmd_valid   (cmd_valid),
    .i_cmd_op      (cmd_op),
    .i_cmd_src     (cmd_src),
    .i_cmd_dst     (cmd_dst),
    .i_acc_we      (acc_we),
    .o_cmd_ready_c (cmd_ready),
    .o_cmd_done_c  (cmd_done),
    .o_cap_imm_c   (w_cap_imm),
    .o_cap_rd_c    (w_cap_rd),
    .o_wr_en_c     (w_wr_en),
`ifdef REGFILE_SWAP_EN
    .o_wr_b_c      (w_wr_b),
    .o_dst         (w_dst),
`endif
    .o_wr_idx_c    (w_wr_idx),
    .o_src         (w_src)
  );

  // Index range checks; a power-of-two array has no out-of-range indices.
  if (NUM_REGS == (1 << AW)) begin : g_full
    assign w_rd_ok  = 1'b1;
    assign w_wr_ok  = 1'b1;
    assign w_src_ok = 1'b1;
`ifdef REGFILE_SWAP_EN
    assign w_dst_ok = 1'b1;
`endif
  end else begin : g_part
    localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);
    assign w_rd_ok  = {1'b0, rd_addr}  < NREGS;
    assign w_wr_ok  = {1'b0, w_wr_idx} < NREGS;
    assign w_src_ok = {1'b0, w_src}    < NREGS;
`ifdef REGFILE_SWAP_EN
    assign w_dst_ok = {1'b0, w_dst}    < NREGS;
`endif
  end

  assign rd_data   = w_rd_ok  ? r_regs[rd_addr] : '0;
  assign acc_out   = r_regs[ACC_A];
  assign w_src_val = w_src_ok ? r_regs[w_src] : '0;
`ifdef REGFILE_SWAP_EN
  assign w_dst_val = w_dst_ok ? r_regs[w_dst] : '0;
  assign w_wr_data = w_wr_b ? r_tmp_b : r_tmp_a;
`else
  assign w_wr_data = r_tmp_a;
`endif

  // Storage: sequencer write plus accumulator port (never the same register together).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr_en && w_wr_ok) begin
        r_regs[w_wr_idx] <= w_wr_data;
      end
      if (acc_we) begin
        r_regs[ACC_A] <= acc_in;
      end
    end
  end

  // Operand A: immediate on LOAD accept, source register in READ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmp_a <= '0;
    end else if (w_cap_imm) begin
      r_tmp_a <= cmd_imm;
    end else if (w_cap_rd) begin
      r_tmp_a <= w_src_val;
    end
  end

`ifdef REGFILE_SWAP_EN
  // Operand B: destination register in READ, written back to source in WRITE2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmp_b <= '0;
    end else if (w_cap_rd) begin
      r_tmp_b <= w_dst_val;
    end
  end
`endif

endmodule
